step_controller: RTL and testbench

- Multi-phase execution sequencer for the 8-bit single-cycle processor. Splits each instruction into FETCH/DECODE/EXECUTE/WRITEBACK phases, each paced by the divider tick.
- Produces one-cycle commit enables that gate PC update, register write and memory write.
- Supports run, single-step and one hardware breakpoint for board debugging.
- Sits between clock_divider/control_unit and the pc, register_file and data_memory enables.

---
 rtl/step_controller_pkg.sv | 40 ++++
 rtl/step_controller_edge_detect.sv | 28 ++
 rtl/step_controller.sv | 119 +++++++++++
 tb/tb_step_controller.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/step_controller_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : step_controller_pkg
//  Purpose  : Phase encodings, opcode constants and FSM state type for the
//             multi-phase execution sequencer.
//  Revision : 1.0  initial release
// ============================================================================
package step_controller_pkg;

    localparam logic [2:0] PH_IDLE      = 3'd0;
    localparam logic [2:0] PH_FETCH     = 3'd1;
    localparam logic [2:0] PH_DECODE    = 3'd2;
    localparam logic [2:0] PH_EXECUTE   = 3'd3;
    localparam logic [2:0] PH_WRITEBACK = 3'd4;

    localparam logic [1:0] OP_ADD    = 2'b00;
    localparam logic [1:0] OP_LOAD   = 2'b01;
    localparam logic [1:0] OP_STORE  = 2'b10;
    localparam logic [1:0] OP_BRANCH = 2'b11;

    // State values equal the externally visible phase code.
    typedef enum logic [2:0] {
        ST_IDLE      = PH_IDLE,
        ST_FETCH     = PH_FETCH,
        ST_DECODE    = PH_DECODE,
        ST_EXECUTE   = PH_EXECUTE,
        ST_WRITEBACK = PH_WRITEBACK
    } state_t;

    function automatic logic writes_register(input logic [1:0] op);
        return (op == OP_ADD) || (op == OP_LOAD);
    endfunction

    function automatic logic writes_memory(input logic [1:0] op);
        return (op == OP_STORE);
    endfunction

endpackage : step_controller_pkg
`default_nettype wire

// File: rtl/step_controller_edge_detect.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : step_controller_edge_detect
//  Purpose  : Rising-edge detector for an already synchronised button level.
//  Revision : 1.0  initial release
// ============================================================================
module step_controller_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic i_level,
    output logic o_rise
);

    logic r_level_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level_q <= 1'b0;
        end else begin
            r_level_q <= i_level;
        end
    end

    assign o_rise = i_level & ~r_level_q;

endmodule : step_controller_edge_detect
`default_nettype wire

// File: rtl/step_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : step_controller
//  Purpose  : FETCH/DECODE/EXECUTE/WRITEBACK sequencer with run, single-step
//             and one hardware breakpoint; emits one-cycle commit enables.
//  Revision : 1.0  initial release
// ============================================================================
module step_controller
    import step_controller_pkg::*;
#(
    parameter int PC_WIDTH    = 8,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clock,
    input  logic                   clear,
    input  logic                   tick,
    input  logic                   run_mode,
    input  logic                   step_request,
    input  logic                   break_enable,
    input  logic [PC_WIDTH-1:0]    break_address,
    input  logic [PC_WIDTH-1:0]    pc_value,
    input  logic [1:0]             opcode,
    output logic [2:0]             phase,
    output logic                   pc_write,
    output logic                   reg_write_enable,
    output logic                   mem_write_enable,
    output logic                   mem_read_enable,
    output logic                   halted,
    output logic                   breakpoint_hit,
    output logic [COUNT_WIDTH-1:0] instr_count
);

    state_t                 r_state;
    logic [1:0]             r_opcode;
    logic                   r_skip_break;
    logic                   r_break_hit;
    logic [COUNT_WIDTH-1:0] r_count;

    logic w_step_edge;
    logic w_start;
    logic w_break_match;
    logic w_commit;

    step_controller_edge_detect u_step_edge (
        .clk     (clock),
        .rst_n   (clear),
        .i_level (step_request),
        .o_rise  (w_step_edge)
    );

    assign w_start       = w_step_edge | run_mode;
    // A resume from a breakpoint stop must get past the very PC it stopped on.
    assign w_break_match = break_enable && (pc_value == break_address) && !r_skip_break;
    assign w_commit      = (r_state == ST_WRITEBACK) && tick;

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_state      <= ST_IDLE;
            r_opcode     <= OP_ADD;
            r_skip_break <= 1'b0;
            r_break_hit  <= 1'b0;
            r_count      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state      <= ST_FETCH;
                        r_break_hit  <= 1'b0;
                        r_skip_break <= r_break_hit;
                    end
                end
                ST_FETCH: begin
                    if (tick) begin
                        if (w_break_match) begin
                            r_state     <= ST_IDLE;
                            r_break_hit <= 1'b1;
                        end else begin
                            r_state      <= ST_DECODE;
                            r_skip_break <= 1'b0;
                        end
                    end
                end
                ST_DECODE: begin
                    if (tick) begin
                        r_opcode <= opcode;
                        r_state  <= ST_EXECUTE;
                    end
                end
                ST_EXECUTE: begin
                    if (tick) begin
                        r_state <= ST_WRITEBACK;
                    end
                end
                ST_WRITEBACK: begin
                    if (tick) begin
                        r_count <= r_count + 1'b1;
                        r_state <= run_mode ? ST_FETCH : ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign phase            = r_state;
    assign halted           = (r_state == ST_IDLE);
    assign pc_write         = w_commit;
    assign reg_write_enable = w_commit && writes_register(r_opcode);
    assign mem_write_enable = w_commit && writes_memory(r_opcode);
    assign mem_read_enable  = ((r_state == ST_EXECUTE) || (r_state == ST_WRITEBACK))
                              && (r_opcode == OP_LOAD);
    assign breakpoint_hit   = r_break_hit;
    assign instr_count      = r_count;

endmodule : step_controller
`default_nettype wire

// File: tb/tb_step_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_step_controller
//  Purpose  : Self-checking bench; expected commits are queued as instructions
//             are launched and matched against every observed commit pulse.
//  Revision : 1.0  initial release
// ============================================================================
module tb_step_controller;

    typedef struct packed {
        logic rw;
        logic mw;
    } exp_t;

    logic        clock = 1'b0;
    logic        clear = 1'b1;
    logic        tick = 1'b0;
    logic        run_mode = 1'b0;
    logic        step_request = 1'b0;
    logic        break_enable = 1'b0;
    logic [7:0]  break_address = 8'h00;
    logic [7:0]  pc_value = 8'h00;
    logic [1:0]  opcode = 2'b00;

    logic [2:0]  phase;
    logic        pc_write, reg_write_enable, mem_write_enable, mem_read_enable;
    logic        halted, breakpoint_hit;
    logic [15:0] instr_count;

    logic [2:0]  s_phase;
    logic        s_pc_write, s_reg_we, s_mem_we, s_mem_re, s_halted, s_hit;
    logic [2:0]  s_count;

    exp_t        q[$];
    exp_t        mon_e;
    logic [15:0] exp_count = 16'd0;
    int          n_checks = 0;
    int          n_errors = 0;

    step_controller u_dut (
        .clock(clock), .clear(clear), .tick(tick), .run_mode(run_mode),
        .step_request(step_request), .break_enable(break_enable),
        .break_address(break_address), .pc_value(pc_value), .opcode(opcode),
        .phase(phase), .pc_write(pc_write), .reg_write_enable(reg_write_enable),
        .mem_write_enable(mem_write_enable), .mem_read_enable(mem_read_enable),
        .halted(halted), .breakpoint_hit(breakpoint_hit), .instr_count(instr_count)
    );

    // Narrow-counter instance sharing all stimulus, used to observe wrap-around.
    step_controller #(.PC_WIDTH(8), .COUNT_WIDTH(3)) u_dut_small (
        .clock(clock), .clear(clear), .tick(tick), .run_mode(run_mode),
        .step_request(step_request), .break_enable(break_enable),
        .break_address(break_address), .pc_value(pc_value), .opcode(opcode),
        .phase(s_phase), .pc_write(s_pc_write), .reg_write_enable(s_reg_we),
        .mem_write_enable(s_mem_we), .mem_read_enable(s_mem_re),
        .halted(s_halted), .breakpoint_hit(s_hit), .instr_count(s_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic clk1();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        clk1();
        tick = 1'b0;
    endtask

    task automatic tick_gap(input int gap);
        repeat (gap) clk1();
        pulse_tick();
    endtask

    task automatic step_once();
        step_request = 1'b1;
        clk1();
        step_request = 1'b0;
    endtask

    task automatic push(input logic rw, input logic mw);
        q.push_back({rw, mw});
    endtask

    // Commit monitor, sampled mid-cycle away from the active edge.
    always @(negedge clock) begin
        if (pc_write || reg_write_enable || mem_write_enable) begin
            if (q.size() == 0) begin
                check("unexpected_commit", 32'({pc_write, reg_write_enable, mem_write_enable}), 32'd0);
            end else begin
                mon_e = q.pop_front();
                check("commit_pc_write", 32'(pc_write), 32'd1);
                check("commit_reg_we", 32'(reg_write_enable), 32'(mon_e.rw));
                check("commit_mem_we", 32'(mem_write_enable), 32'(mon_e.mw));
                check("commit_tick", 32'(tick), 32'd1);
                check("count_at_commit", 32'(instr_count), 32'(exp_count));
                exp_count = exp_count + 16'd1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [1:0] mrd_exp [4];

        // Reset is asynchronous: outputs settle before any clock edge.
        #1 clear = 1'b0;
        #1;
        check("rst_phase", 32'(phase), 32'd0);
        check("rst_halted", 32'(halted), 32'd1);
        check("rst_enables", 32'({pc_write, reg_write_enable, mem_write_enable, mem_read_enable}), 32'd0);
        check("rst_hit", 32'(breakpoint_hit), 32'd0);
        check("rst_count", 32'(instr_count), 32'd0);
        clk1();
        clk1();
        clear = 1'b1;

        // Free run, opcode ADD, tick every 4 clocks; stop after third commit.
        opcode   = 2'b00;
        run_mode = 1'b1;
        clk1();
        check("run_enter_fetch", 32'(phase), 32'd1);
        for (int k = 1; k <= 12; k++) begin
            if (k % 4 == 0) push(1'b1, 1'b0);
            if (k == 12) run_mode = 1'b0;
            tick_gap(3);
            check("run_phase", 32'(phase), (k == 12) ? 32'd0 : 32'((k % 4) + 1));
        end
        check("run_count", 32'(instr_count), 32'd3);
        check("run_halted", 32'(halted), 32'd1);

        // Single step of a STORE.
        opcode = 2'b10;
        step_once();
        check("step_fetch", 32'(phase), 32'd1);
        push(1'b0, 1'b1);
        repeat (4) tick_gap(3);
        check("step_idle", 32'(phase), 32'd0);
        check("step_halted", 32'(halted), 32'd1);
        check("step_count", 32'(instr_count), 32'd4);

        // Breakpoint stop, then resume past it, then hit again.
        opcode        = 2'b00;
        break_enable  = 1'b1;
        break_address = 8'h05;
        pc_value      = 8'h05;
        step_once();
        tick_gap(1);
        check("bp_phase", 32'(phase), 32'd0);
        check("bp_hit", 32'(breakpoint_hit), 32'd1);
        check("bp_no_commit_count", 32'(instr_count), 32'd4);
        repeat (3) clk1();
        check("bp_hit_sticky", 32'(breakpoint_hit), 32'd1);
        step_once();
        check("bp_resume_phase", 32'(phase), 32'd1);
        check("bp_resume_hit_clr", 32'(breakpoint_hit), 32'd0);
        push(1'b1, 1'b0);
        repeat (4) tick_gap(1);
        check("bp_resume_count", 32'(instr_count), 32'd5);
        check("bp_resume_idle", 32'(phase), 32'd0);
        step_once();
        tick_gap(1);
        check("bp_rehit", 32'(breakpoint_hit), 32'd1);
        check("bp_rehit_phase", 32'(phase), 32'd0);
        break_enable = 1'b0;

        // LOAD: read enable only in EXECUTE and WRITEBACK.
        opcode     = 2'b01;
        mrd_exp[0] = 2'd0;
        mrd_exp[1] = 2'd1;
        mrd_exp[2] = 2'd1;
        mrd_exp[3] = 2'd0;
        step_once();
        check("ld_fetch_mrd", 32'(mem_read_enable), 32'd0);
        push(1'b1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            tick_gap(1);
            check("ld_mrd", 32'(mem_read_enable), 32'(mrd_exp[k]));
        end
        check("ld_count", 32'(instr_count), 32'd6);

        // Counter wrap on the narrow instance, BRANCH commits PC only.
        opcode = 2'b11;
        n = 7 - int'(exp_count[2:0]);
        if (n > 0) begin
            run_mode = 1'b1;
            clk1();
            tick = 1'b1;
            for (int i = 0; i < n; i++) begin
                push(1'b0, 1'b0);
                if (i == n - 1) run_mode = 1'b0;
                repeat (4) clk1();
            end
            tick = 1'b0;
        end
        check("wrap_pre_small", 32'(s_count), 32'd7);
        check("wrap_pre_main", 32'(instr_count), 32'(exp_count));
        step_once();
        push(1'b0, 1'b0);
        tick = 1'b1;
        repeat (4) clk1();
        tick = 1'b0;
        check("wrap_small_zero", 32'(s_count), 32'd0);
        check("wrap_main_count", 32'(instr_count), 32'd8);

        // Reset in EXECUTE aborts without a commit, even with tick high.
        opcode = 2'b01;
        step_once();
        tick_gap(1);
        tick_gap(1);
        check("abort_pre_phase", 32'(phase), 32'd3);
        check("abort_pre_mrd", 32'(mem_read_enable), 32'd1);
        tick  = 1'b1;
        clear = 1'b0;
        exp_count = 16'd0;
        #1;
        check("abort_phase", 32'(phase), 32'd0);
        check("abort_outputs", 32'({pc_write, reg_write_enable, mem_write_enable, mem_read_enable, breakpoint_hit}), 32'd0);
        check("abort_count", 32'(instr_count), 32'd0);
        clk1();
        clk1();
        tick  = 1'b0;
        clear = 1'b1;
        clk1();

        // Held step button launches only one instruction.
        opcode       = 2'b00;
        step_request = 1'b1;
        clk1();
        check("hold_fetch", 32'(phase), 32'd1);
        push(1'b1, 1'b0);
        repeat (4) tick_gap(2);
        repeat (6) tick_gap(1);
        check("hold_idle", 32'(phase), 32'd0);
        check("hold_count", 32'(instr_count), 32'd1);
        step_request = 1'b0;
        clk1();

        check("queue_empty", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_step_controller
`default_nettype wire
